// File: rtl/hex_entry_if.sv
// rtl/hex_entry_if.sv - key-pulse inputs, edit buffer view and committed-value handshake
interface hex_entry_if #(
    parameter int DIGITS = 8,
    parameter int CNTW   = 4
);
    logic [15:0]         hd_ps;
    logic                ent_ps;
    logic                del_ps;
    logic                out_ready;
    logic [4*DIGITS-1:0] edit_buf;
    logic [CNTW-1:0]     edit_cnt;
    logic [4*DIGITS-1:0] out_data;
    logic                out_valid;
    logic                err;

    modport master (
        output hd_ps, ent_ps, del_ps, out_ready,
        input  edit_buf, edit_cnt, out_data, out_valid, err
    );

    modport slave (
        input  hd_ps, ent_ps, del_ps, out_ready,
        output edit_buf, edit_cnt, out_data, out_valid, err
    );
endinterface

// File: rtl/hex_entry.sv
// rtl/hex_entry.sv - hex digit edit buffer with enter/delete and valid/ready commit
module hex_entry #(
    parameter int DIGITS = 8,
    parameter int CNTW   = 4
) (
    input  logic        clk,
    input  logic        rstn,
    hex_entry_if.slave  bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {EMPTY, PART, FULL} state_t;

    state_t          r_state;
    logic [W-1:0]    r_buf;
    logic [CNTW-1:0] r_cnt;
    logic [W-1:0]    r_out;
    logic            r_valid;
    logic            r_err;

    logic [3:0]      w_digit;
    logic            w_hd_any;
    logic            w_hd_multi;
    logic            w_ent_ok;
    logic [W-1:0]    w_shift;

    always_comb begin
        w_digit = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (bus.hd_ps[k]) w_digit = 4'(k);
        end
    end

    assign w_hd_any   = |bus.hd_ps;
    assign w_hd_multi = (bus.hd_ps & (bus.hd_ps - 16'd1)) != 16'd0;
    assign w_ent_ok   = !r_valid || bus.out_ready;
    assign w_shift    = (r_buf << 4) | W'(w_digit);

    // Each branch is one priority level; dropped lower-priority pulses raise err.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= EMPTY;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (r_valid && bus.out_ready) r_valid <= 1'b0;

            if (bus.ent_ps) begin
                if (w_ent_ok) begin
                    r_out   <= r_buf;
                    r_valid <= 1'b1;
                    r_buf   <= '0;
                    r_cnt   <= '0;
                    r_state <= EMPTY;
                end else begin
                    r_err <= 1'b1;
                end
                if (bus.del_ps || w_hd_any) r_err <= 1'b1;
            end else if (bus.del_ps) begin
                if (w_hd_any) r_err <= 1'b1;
                if (r_state == EMPTY) begin
                    r_err <= 1'b1;
                end else begin
                    r_buf   <= r_buf >> 4;
                    r_cnt   <= r_cnt - 1'b1;
                    r_state <= (r_cnt == CNTW'(1)) ? EMPTY : PART;
                end
            end else if (w_hd_any) begin
                if (w_hd_multi) begin
                    r_err <= 1'b1;
                end else begin
                    // Shift even when full: oldest nibble falls off, err warns.
                    r_buf <= w_shift;
                    if (r_state == FULL) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= (r_cnt == CNTW'(DIGITS - 1)) ? FULL : PART;
                    end
                end
            end
        end
    end

    assign bus.edit_buf  = r_buf;
    assign bus.edit_cnt  = r_cnt;
    assign bus.out_data  = r_out;
    assign bus.out_valid = r_valid;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_hex_entry.sv
// tb/tb_hex_entry.sv - directed and randomized bench for hex_entry against a digit-queue model
module tb_hex_entry;
    localparam int DIGITS = 8;
    localparam int CNTW   = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    hex_entry_if #(.DIGITS(DIGITS), .CNTW(CNTW)) bus ();

    hex_entry #(.DIGITS(DIGITS), .CNTW(CNTW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: queue of typed digits, oldest first.
    int          m_q[$];
    logic [31:0] m_out;
    logic        m_valid;
    logic        m_err;

    function automatic logic [31:0] m_buf();
        logic [31:0] v = 32'd0;
        foreach (m_q[i]) v = (v << 4) | 32'(m_q[i]);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [15:0] hd, input logic e, input logic d,
                              input logic r, input logic rs);
        int  ones;
        int  k;
        logic accept;
        if (!rs) begin
            m_q.delete();
            m_out = 32'd0; m_valid = 1'b0; m_err = 1'b0;
            return;
        end
        ones = $countones(hd);
        m_err = 1'b0;
        accept = e && (!m_valid || r);
        if (m_valid && r) m_valid = 1'b0;
        if (e) begin
            if (accept) begin
                m_out = m_buf();
                m_valid = 1'b1;
                m_q.delete();
            end else begin
                m_err = 1'b1;
            end
            if (d || ones != 0) m_err = 1'b1;
        end else if (d) begin
            if (ones != 0) m_err = 1'b1;
            if (m_q.size() == 0) m_err = 1'b1;
            else void'(m_q.pop_back());
        end else if (ones > 1) begin
            m_err = 1'b1;
        end else if (ones == 1) begin
            k = 0;
            for (int i = 0; i < 16; i++) if (hd[i]) k = i;
            if (m_q.size() == DIGITS) begin
                void'(m_q.pop_front());
                m_err = 1'b1;
            end
            m_q.push_back(k);
        end
    endtask

    task automatic cyc(input logic [15:0] hd, input logic e, input logic d,
                       input logic r, input logic rs);
        bus.hd_ps = hd; bus.ent_ps = e; bus.del_ps = d; bus.out_ready = r; rstn = rs;
        @(posedge clk); #1;
        model_step(hd, e, d, r, rs);
        chk("edit_buf",  bus.edit_buf, m_buf());
        chk("edit_cnt",  32'(bus.edit_cnt), 32'(m_q.size()));
        chk("out_data",  bus.out_data, m_out);
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("err",       32'(bus.err), 32'(m_err));
        bus.hd_ps = 16'd0; bus.ent_ps = 1'b0; bus.del_ps = 1'b0; rstn = 1'b1;
    endtask

    task automatic key(input int k, input logic r);
        cyc(16'(1 << k), 1'b0, 1'b0, r, 1'b1);
    endtask

    initial begin
        logic [15:0] hd;
        logic        e, d, r, rs;
        m_q.delete(); m_out = 32'd0; m_valid = 1'b0; m_err = 1'b0;
        bus.hd_ps = 16'd0; bus.ent_ps = 1'b0; bus.del_ps = 1'b0; bus.out_ready = 1'b1;

        cyc(16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("reset_buf", bus.edit_buf, 32'd0);

        key(1, 1); key(2, 1); key(3, 1);
        chk("tp1_buf", bus.edit_buf, 32'h0000_0123);
        cyc(16'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("tp1_out", bus.out_data, 32'h0000_0123);
        cyc(16'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        for (int i = 1; i <= 8; i++) key(i, 1);
        chk("full_buf", bus.edit_buf, 32'h1234_5678);
        key(9, 1);
        chk("ovf_buf", bus.edit_buf, 32'h2345_6789);
        chk("ovf_err", 32'(bus.err), 32'd1);
        cyc(16'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(16'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        key(10, 1); key(11, 1);
        cyc(16'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("del1_buf", bus.edit_buf, 32'h0000_000A);
        cyc(16'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(16'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("del_empty_err", 32'(bus.err), 32'd1);

        cyc(16'h0003, 1'b0, 1'b0, 1'b1, 1'b1);
        key(7, 1);
        cyc(16'h0020, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("prio_out", bus.out_data, 32'h0000_0007);
        chk("prio_err", 32'(bus.err), 32'd1);
        cyc(16'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        key(5, 0);
        cyc(16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cyc(16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        key(6, 0);
        cyc(16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("refuse_buf", bus.edit_buf, 32'h0000_0006);
        chk("refuse_out", bus.out_data, 32'h0000_0005);
        cyc(16'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(16'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("drain_valid", 32'(bus.out_valid), 32'd0);

        cyc(16'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        key(1, 0); key(15, 0);
        cyc(16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        key(3, 0);
        chk("post_rst_cnt", 32'(bus.edit_cnt), 32'd1);

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: hd = 16'd0;
                9:          hd = 16'($urandom);
                default:    hd = 16'(1 << $urandom_range(0, 15));
            endcase
            e  = ($urandom_range(0, 11) == 0);
            d  = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 2) != 0);
            rs = ($urandom_range(0, 299) != 0);
            cyc(hd, e, d, r, rs);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hex_entry.md
Name: hex_entry

Overview:
- Consumes the single-cycle pulses from the debounce/edge-detect front end: 16 hex-key pulses, enter and delete.
- Assembles typed hex digits into an edit buffer, right-aligned, newest digit in the LSB nibble.
- On enter, commits the buffer to a valid/ready output for downstream consumers (register/memory write, display, CPU debug port).
- Sits between the button conditioning stage and the lab's data/address entry logic.

Parameters:
DIGITS, 8, number of hex digits held in the edit buffer; buffer and output width = 4*DIGITS
CNTW, 4, width of the digit counter; must satisfy 2^CNTW > DIGITS

Ports:
clk  input  1  system clock; all state updates on the rising edge
rstn  input  1  synchronous active-low reset, sampled on the rising edge of clk
hd_ps  input  16  hex-key pulses; bit k high for one cycle means digit k was pressed
ent_ps  input  1  enter pulse, one cycle
del_ps  input  1  delete/backspace pulse, one cycle
edit_buf  output  4*DIGITS  current edit buffer, for display
edit_cnt  output  CNTW  number of valid digits in edit_buf, 0..DIGITS
out_data  output  4*DIGITS  committed value; stable while out_valid=1
out_valid  output  1  committed value available
out_ready  input  1  downstream accepts out_data when out_valid=1 and out_ready=1 in the same cycle
err  output  1  one-cycle pulse flagging a dropped or illegal input

Behaviour:
- Reset: one clock, reset synchronous and active-low (rstn). While rstn=0 at a clock edge:
  - edit_buf=0, edit_cnt=0, out_data=0, out_valid=0, err=0
  - FSM enters EMPTY
  - Reset mid-entry or mid-handshake discards everything, including an un-accepted out_data.
- Edit FSM states:
  - EMPTY: cnt=0
  - PART: 0<cnt<DIGITS
  - FULL: cnt=DIGITS
  - The state is registered and must always agree with edit_cnt.
- Input decode, each cycle, with priority ent_ps > del_ps > hd_ps. Lower-priority events in the same cycle are dropped and err pulses the next cycle.
- hd_ps handling:
  - If hd_ps is not one-hot (two or more bits set), it is dropped and err pulses.
  - hd_ps==0 means no digit event.
- Digit k, accepted when no ent_ps or del_ps in the same cycle:
  - edit_buf <= {edit_buf[4*DIGITS-5:0], k[3:0]}
  - EMPTY->PART, or EMPTY->FULL when DIGITS=1; PART->PART, or PART->FULL when cnt reaches DIGITS; cnt increments.
  - In FULL: the shift still occurs (oldest nibble lost), cnt stays DIGITS, state stays FULL, and err pulses (overflow warning).
- Delete:
  - edit_buf <= edit_buf>>4; cnt decrements.
  - FULL->PART, or FULL->EMPTY when DIGITS=1; PART->PART, or PART->EMPTY when cnt reaches 0.
  - In EMPTY: no change; err pulses.
- Enter, accepted when out_valid==0 or out_ready==1 in that cycle:
  - out_data <= edit_buf; out_valid <= 1
  - edit_buf <= 0; cnt <= 0; state <= EMPTY
  - Enter in EMPTY commits 0 (legal, no err).
- Enter refused when out_valid==1 and out_ready==0:
  - edit buffer is untouched, out_data is unchanged, err pulses.
- Output handshake:
  - When out_valid && out_ready && no accepted enter: out_valid <= 0 next cycle; out_data holds its value.
  - Accept and new enter in the same cycle: out_valid stays 1 and out_data takes the new value (back-to-back transfer).
  - out_data must not change while out_valid=1 && out_ready=0.
- Latency:
  - All effects appear on outputs one cycle after the pulse edge.
  - err is registered and lasts exactly one cycle per offending cycle.
- Editing is independent of the output handshake: digits and deletes are accepted while out_valid=1.

Test Plan:
- Reset, then pulse hd_ps bits 1,2,3 in separate cycles -> edit_buf=0x00000123, edit_cnt=3, err never high; then ent_ps with out_ready=1 -> out_data=0x00000123, out_valid=1 for one cycle, edit_buf=0, edit_cnt=0.
- Enter 9 digits 1..9 (DIGITS=8) -> after 8th edit_cnt=8, edit_buf=0x12345678; 9th -> edit_buf=0x23456789, edit_cnt=8, err one-cycle pulse.
- Digits A,B then del_ps twice then del_ps again -> edit_buf 0xAB, 0xA, 0x0; cnt 2,1,0; third delete -> err pulse, state stays EMPTY.
- hd_ps=16'h0003 -> no change, err pulse; ent_ps+del_ps+hd_ps[5] same cycle with buffer 0x7 -> out_data=0x7, buffer cleared, err pulse.
- out_ready=0: enter 0x5 -> out_valid=1 held for 10 cycles with out_data=0x5; second enter with buffer 0x6 -> refused, err pulse, edit_buf still 0x6; raise out_ready -> out_valid drops next cycle.
- Buffer 0x1F, out_valid=1: drive rstn=0 for one cycle -> all outputs 0, edit_cnt=0; first digit after reset lands at cnt=1.
